// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - state codes, field codes, BCD limits and helpers for clock_ctrl
package clock_pkg;

  localparam logic [2:0] ST_RUN       = 3'd0;
  localparam logic [2:0] ST_SET_TIME  = 3'd1;
  localparam logic [2:0] ST_SET_ALARM = 3'd2;
  localparam logic [2:0] ST_RING      = 3'd3;
  localparam logic [2:0] ST_SNOOZE    = 3'd4;

  localparam logic [1:0] F_HH = 2'd3;
  localparam logic [1:0] F_MM = 2'd2;
  localparam logic [1:0] F_SS = 2'd1;
  localparam logic [1:0] F_CC = 2'd0;

  localparam logic [7:0] LIM_HH = 8'h23;
  localparam logic [7:0] LIM_MS = 8'h59;

  // Values at or above the limit wrap, so a corrupt source byte still lands on 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    if (v >= lim) return 8'h00;
    if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] field_limit(input logic [1:0] f);
    return (f == F_HH) ? LIM_HH : LIM_MS;
  endfunction

  // Segments {g,f,e,d,c,b,a}, active high.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

endpackage

// File: rtl/clock_ctrl_btn_sync.sv
// rtl/clock_ctrl_btn_sync.sv - two-flop synchronizer with rising-edge pulse
module btn_sync (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;

endmodule

// File: rtl/clock_ctrl.sv
// rtl/clock_ctrl.sv - alarm clock control FSM: tick divider, time/alarm set, ring and snooze
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 500000,
  parameter int unsigned RING_TICKS   = 6000,
  parameter int unsigned SNOOZE_TICKS = 30000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_next,
  input  logic        btn_inc,
  input  logic        btn_snooze,
  input  logic        alarm_en,
  input  logic [31:0] cur_time,
  output logic        tick,
  output logic        load_en,
  output logic [1:0]  load_field,
  output logic [7:0]  load_value,
  output logic [31:0] alarm_time,
  output logic        alarm_sound,
  output logic [2:0]  state
);

  localparam int DIV_W  = $clog2(TICK_DIV);
  localparam int RING_W = $clog2(RING_TICKS);
  localparam int SNZ_W  = $clog2(SNOOZE_TICKS);

  logic mode_p, next_p, inc_p, snz_p, alarm_on;
  logic mode_lvl, next_lvl, inc_lvl, snz_lvl, alarm_rise;
  logic unused_sig;

  btn_sync u_mode   (.CLOCK_50(CLOCK_50), .reset(reset), .din(btn_mode),   .level(mode_lvl), .rise(mode_p));
  btn_sync u_next   (.CLOCK_50(CLOCK_50), .reset(reset), .din(btn_next),   .level(next_lvl), .rise(next_p));
  btn_sync u_inc    (.CLOCK_50(CLOCK_50), .reset(reset), .din(btn_inc),    .level(inc_lvl),  .rise(inc_p));
  btn_sync u_snooze (.CLOCK_50(CLOCK_50), .reset(reset), .din(btn_snooze), .level(snz_lvl),  .rise(snz_p));
  btn_sync u_alarm  (.CLOCK_50(CLOCK_50), .reset(reset), .din(alarm_en),   .level(alarm_on), .rise(alarm_rise));

  assign unused_sig = ^{mode_lvl, next_lvl, inc_lvl, snz_lvl, alarm_rise};

  logic [DIV_W-1:0]  div;
  logic              tick_raw;
  logic [RING_W-1:0] ring_cnt;
  logic [SNZ_W-1:0]  snz_cnt;
  logic [1:0]        fp;
  logic [7:0]        eb;
  logic [7:0]        al_hh, al_mm, al_ss;
  logic              clr_pend;
  logic [1:0]        fp_nxt;
  logic [31:0]       src_word;
  logic [7:0]        src_byte;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      div      <= '0;
      tick_raw <= 1'b0;
    end else if (div == DIV_W'(TICK_DIV - 1)) begin
      div      <= '0;
      tick_raw <= 1'b1;
    end else begin
      div      <= div + 1'b1;
      tick_raw <= 1'b0;
    end
  end

  // Gate on the live state so no tick leaks into the first SET_TIME cycle.
  assign tick        = tick_raw && (state != ST_SET_TIME);
  assign alarm_sound = (state == ST_RING);
  assign alarm_time  = {al_hh, al_mm, al_ss, 8'h00};

  assign fp_nxt   = fp - 2'd1;
  assign src_word = (state == ST_SET_TIME) ? cur_time : alarm_time;
  assign src_byte = src_word[{fp_nxt, 3'b000} +: 8];

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= ST_RUN;
      fp         <= F_HH;
      eb         <= 8'h00;
      ring_cnt   <= '0;
      snz_cnt    <= '0;
      al_hh      <= 8'h00;
      al_mm      <= 8'h00;
      al_ss      <= 8'h00;
      load_en    <= 1'b0;
      load_field <= F_CC;
      load_value <= 8'h00;
      clr_pend   <= 1'b0;
    end else begin
      load_en  <= 1'b0;
      clr_pend <= 1'b0;
      // Trailing CC clear after a SET_TIME seconds commit; state is already RUN here.
      if (clr_pend) begin
        load_en    <= 1'b1;
        load_field <= F_CC;
        load_value <= 8'h00;
      end
      case (state)
        ST_RUN: begin
          if (mode_p) begin
            state <= ST_SET_TIME;
            fp    <= F_HH;
            eb    <= cur_time[31:24];
          end else if (alarm_on && tick && (cur_time == alarm_time)) begin
            state    <= ST_RING;
            ring_cnt <= '0;
          end
        end
        ST_SET_TIME, ST_SET_ALARM: begin
          if (mode_p) begin
            if (state == ST_SET_TIME) begin
              state <= ST_SET_ALARM;
              fp    <= F_HH;
              eb    <= al_hh;
            end else begin
              state <= ST_RUN;
            end
          end else if (next_p) begin
            if (state == ST_SET_TIME) begin
              load_en    <= 1'b1;
              load_field <= fp;
              load_value <= eb;
            end else begin
              case (fp)
                F_HH:    al_hh <= eb;
                F_MM:    al_mm <= eb;
                default: al_ss <= eb;
              endcase
            end
            if (fp == F_SS) begin
              state    <= ST_RUN;
              clr_pend <= (state == ST_SET_TIME);
            end else begin
              fp <= fp_nxt;
              eb <= src_byte;
            end
          end else if (inc_p) begin
            eb <= bcd_inc(eb, field_limit(fp));
          end
        end
        ST_RING: begin
          if (mode_p || !alarm_on) begin
            state <= ST_RUN;
          end else if (snz_p) begin
            state   <= ST_SNOOZE;
            snz_cnt <= '0;
          end else if (tick) begin
            if (ring_cnt == RING_W'(RING_TICKS - 1)) state <= ST_RUN;
            else ring_cnt <= ring_cnt + 1'b1;
          end
        end
        ST_SNOOZE: begin
          if (mode_p || !alarm_on) begin
            state <= ST_RUN;
          end else if (tick) begin
            if (snz_cnt == SNZ_W'(SNOOZE_TICKS - 1)) begin
              state    <= ST_RING;
              ring_cnt <= '0;
            end else begin
              snz_cnt <= snz_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_ctrl.sv
// tb/tb_clock_ctrl.sv - directed scoreboard bench for clock_ctrl
module tb_clock_ctrl;
  import clock_pkg::*;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        btn_mode = 1'b0, btn_next = 1'b0, btn_inc = 1'b0, btn_snooze = 1'b0;
  logic        alarm_en = 1'b0;
  logic [31:0] cur_time = 32'h0;
  logic        tick, load_en, alarm_sound;
  logic [1:0]  load_field;
  logic [7:0]  load_value;
  logic [31:0] alarm_time;
  logic [2:0]  state;

  int total = 0;
  int bad = 0;
  int set_ticks = 0;
  logic [9:0] exp_q[$];

  clock_ctrl #(.TICK_DIV(4), .RING_TICKS(8), .SNOOZE_TICKS(6)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc), .btn_snooze(btn_snooze),
    .alarm_en(alarm_en), .cur_time(cur_time), .tick(tick),
    .load_en(load_en), .load_field(load_field), .load_value(load_value),
    .alarm_time(alarm_time), .alarm_sound(alarm_sound), .state(state)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (load_en === 1'b1) begin
      if (exp_q.size() == 0) check("load_unexpected", {31'd0, load_en}, 32'd0);
      else check("load_pulse", {22'd0, load_field, load_value}, {22'd0, exp_q.pop_front()});
    end
    if (tick === 1'b1 && state == ST_SET_TIME) set_ticks++;
  end

  task automatic press(input logic m, input logic n, input logic i, input logic s);
    @(negedge CLOCK_50);
    btn_mode = m; btn_next = n; btn_inc = i; btn_snooze = s;
    repeat (4) @(negedge CLOCK_50);
    btn_mode = 0; btn_next = 0; btn_inc = 0; btn_snooze = 0;
    repeat (4) @(negedge CLOCK_50);
  endtask

  initial begin
    int n, ticks;
    logic seen, sound_bad;

    // Reset release and tick cadence
    repeat (3) @(negedge CLOCK_50);
    reset = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge CLOCK_50); #1;
      check($sformatf("tick_c%0d", cyc), {31'd0, tick}, {31'd0, (cyc % 4) == 0});
    end
    check("rst_state", {29'd0, state}, {29'd0, ST_RUN});
    check("rst_load_en", {31'd0, load_en}, 32'd0);
    check("rst_load_fv", {22'd0, load_field, load_value}, 32'd0);
    check("rst_alarm_time", alarm_time, 32'd0);
    check("rst_sound", {31'd0, alarm_sound}, 32'd0);

    // SET_TIME: wrap HH, walk fields, trailing CC clear
    cur_time = 32'h23590000;
    set_ticks = 0;
    press(1, 0, 0, 0);
    check("enter_set_time", {29'd0, state}, {29'd0, ST_SET_TIME});
    press(0, 0, 1, 0);
    exp_q.push_back({F_HH, 8'h00});
    press(0, 1, 0, 0);
    exp_q.push_back({F_MM, 8'h59});
    press(0, 1, 0, 0);
    exp_q.push_back({F_SS, 8'h00});
    exp_q.push_back({F_CC, 8'h00});
    press(0, 1, 0, 0);
    check("set_time_done", {29'd0, state}, {29'd0, ST_RUN});
    cur_time = 32'h12345600;
    press(1, 0, 0, 0);
    exp_q.push_back({F_HH, 8'h12});
    press(0, 1, 0, 0);
    exp_q.push_back({F_MM, 8'h34});
    press(0, 1, 0, 0);
    exp_q.push_back({F_SS, 8'h56});
    exp_q.push_back({F_CC, 8'h00});
    press(0, 1, 0, 0);
    check("set_time_done2", {29'd0, state}, {29'd0, ST_RUN});
    check("no_tick_in_set", set_ticks, 32'd0);
    check("loads_drained1", exp_q.size(), 32'd0);

    // SET_ALARM to 07:30:00
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    check("enter_set_alarm", {29'd0, state}, {29'd0, ST_SET_ALARM});
    repeat (7) press(0, 0, 1, 0);
    press(0, 1, 0, 0);
    repeat (30) press(0, 0, 1, 0);
    press(0, 1, 0, 0);
    press(0, 1, 0, 0);
    check("alarm_time", alarm_time, 32'h07300000);
    check("set_alarm_done", {29'd0, state}, {29'd0, ST_RUN});

    // Alarm match -> RING one cycle after the tick
    cur_time = 32'h07300000;
    alarm_en = 1;
    repeat (4) @(negedge CLOCK_50);
    n = 0;
    @(posedge CLOCK_50); #1;
    while (!(tick === 1'b1 && state == ST_RUN) && n < 50) begin
      @(posedge CLOCK_50); #1; n++;
    end
    check("ring_wait", {31'd0, n < 50}, 32'd1);
    @(posedge CLOCK_50); #1;
    check("ring_state", {29'd0, state}, {29'd0, ST_RING});
    check("ring_sound", {31'd0, alarm_sound}, 32'd1);
    cur_time = 32'h07300100;

    // Snooze lasts 6 ticks, silent, then rings again
    btn_snooze = 1; n = 0; ticks = 0; sound_bad = 0; seen = 0;
    while (n < 200 && !(seen && state == ST_RING)) begin
      @(posedge CLOCK_50); #1; n++;
      if (n == 4) btn_snooze = 0;
      if (state == ST_SNOOZE) begin
        seen = 1;
        if (tick) ticks++;
        if (alarm_sound) sound_bad = 1;
      end
    end
    check("snooze_seen", {31'd0, seen}, 32'd1);
    check("snooze_ticks", ticks, 32'd6);
    check("snooze_silent", {31'd0, sound_bad}, 32'd0);
    check("resnooze_sound", {31'd0, alarm_sound}, 32'd1);

    // Unattended ring ends after 8 ticks
    ticks = 0; n = 0;
    while (state == ST_RING && n < 200) begin
      if (tick) ticks++;
      @(posedge CLOCK_50); #1; n++;
    end
    check("ring_ticks", ticks, 32'd8);
    check("ring_timeout_state", {29'd0, state}, {29'd0, ST_RUN});
    check("ring_timeout_sound", {31'd0, alarm_sound}, 32'd0);

    // Reset during RING
    cur_time = 32'h07300000;
    n = 0;
    while (state != ST_RING && n < 100) begin
      @(posedge CLOCK_50); #1; n++;
    end
    check("ring2_reach", {29'd0, state}, {29'd0, ST_RING});
    #2 reset = 1;
    #1;
    check("rr_state", {29'd0, state}, {29'd0, ST_RUN});
    check("rr_sound", {31'd0, alarm_sound}, 32'd0);
    check("rr_alarm_time", alarm_time, 32'd0);
    check("rr_tick", {31'd0, tick}, 32'd0);
    check("rr_load_en", {31'd0, load_en}, 32'd0);
    @(negedge CLOCK_50);
    reset = 0;
    alarm_en = 0;

    // Reset mid-edit: no load pulse, alarm stays 0
    cur_time = 32'h15000000;
    press(1, 0, 0, 0);
    press(0, 0, 1, 0);
    @(negedge CLOCK_50);
    btn_next = 1;
    @(posedge CLOCK_50); @(posedge CLOCK_50); #1;
    reset = 1;
    #1;
    check("re_state", {29'd0, state}, {29'd0, ST_RUN});
    check("re_alarm_time", alarm_time, 32'd0);
    @(negedge CLOCK_50);
    btn_next = 0;
    reset = 0;
    repeat (4) @(negedge CLOCK_50);

    // Simultaneous mode+next+inc acts as mode only
    press(1, 1, 1, 0);
    check("simul_state", {29'd0, state}, {29'd0, ST_SET_TIME});
    exp_q.push_back({F_HH, 8'h15});
    press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    check("simul_exit", {29'd0, state}, {29'd0, ST_RUN});

    repeat (4) @(negedge CLOCK_50);
    check("loads_drained2", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
